// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the multicycle controller (states, opcodes, ALU ops, conditions, mux selects).
package cpu_pkg;
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_LATCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEMRD  = 3'd4,
        S_LDWB   = 3'd5
    } state_t;
    // Major opcodes in instr[15:12]; immediate ALU ops reuse their R-type ext code as opcode.
    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_MEM   = 4'h4;
    localparam logic [3:0] OP_SHIFT = 4'h8;
    localparam logic [3:0] OP_BCOND = 4'hC;
    localparam logic [3:0] OP_LUI   = 4'hE;
    localparam logic [3:0] F_AND = 4'h1;
    localparam logic [3:0] F_OR  = 4'h2;
    localparam logic [3:0] F_XOR = 4'h3;
    localparam logic [3:0] F_ADD = 4'h5;
    localparam logic [3:0] F_SUB = 4'h9;
    localparam logic [3:0] F_CMP = 4'hB;
    localparam logic [3:0] F_MOV = 4'hD;
    localparam logic [3:0] EXT_LOAD  = 4'h0;
    localparam logic [3:0] EXT_STOR  = 4'h4;
    localparam logic [3:0] EXT_JAL   = 4'h8;
    localparam logic [3:0] EXT_JCOND = 4'hC;
    localparam logic [3:0] EXT_LSHI  = 4'h0;
    localparam logic [3:0] EXT_LSH   = 4'h4;
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_CMP = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd5;
    localparam logic [3:0] ALU_LSH = 4'd6;
    localparam logic [3:0] C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3;
    localparam logic [3:0] C_HI = 4'h4, C_LS = 4'h5, C_GT = 4'h6, C_LE = 4'h7;
    localparam logic [3:0] C_FS = 4'h8, C_FC = 4'h9, C_LO = 4'hA, C_HS = 4'hB;
    localparam logic [3:0] C_LT = 4'hC, C_GE = 4'hD, C_UC = 4'hE;
    localparam logic [1:0] PC_INC = 2'd0, PC_JMP = 2'd1, PC_BR = 2'd2;
    localparam logic [1:0] MA_PC = 2'd0, MA_REG = 2'd1;
    localparam logic [1:0] A2_REG = 2'd0, A2_SHAMT = 2'd1, A2_IMM = 2'd2;
    localparam logic [1:0] RW_MEM = 2'd0, RW_PC = 2'd1, RW_ALU = 2'd2, RW_LUI = 2'd3;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: evaluates a 4-bit branch/jump condition against PSR flags {C,F} and {Z,N,L}.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [1:0] flags1,
    input  logic [2:0] flags2,
    output logic       take
);
    logic c, f, z, n, l;
    assign {c, f} = flags1;
    assign {z, n, l} = flags2;
    always_comb begin
        take = 1'b0;
        case (cond)
            C_EQ: take = z;
            C_NE: take = !z;
            C_CS: take = c;
            C_CC: take = !c;
            C_HI: take = l;
            C_LS: take = !l;
            C_GT: take = n;
            C_LE: take = !n;
            C_FS: take = f;
            C_FC: take = !f;
            C_LO: take = !l && !z;
            C_HS: take = l || z;
            C_LT: take = !n && !z;
            C_GE: take = n || z;
            C_UC: take = 1'b1;
            default: take = 1'b0;
        endcase
    end
endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: multicycle fetch/decode/execute control FSM for the 16-bit datapath.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int SIZE = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic [SIZE-1:0] instr,
    input  logic [1:0]      flags1,
    input  logic [2:0]      flags2,
    output logic            MemW1en,
    output logic            MemW2en,
    output logic            RFen,
    output logic            PSRen,
    output logic            PCen,
    output logic            INSTRen,
    output logic            Movm,
    output logic            A1m,
    output logic            setZNL,
    output logic [1:0]      PCm,
    output logic [1:0]      MAm,
    output logic [1:0]      A2m,
    output logic [1:0]      RWm,
    output logic [3:0]      aluOp,
    output logic            halted,
    output logic [2:0]      state_dbg
);
    state_t state, next;
    logic [3:0] op, ext, fn, alu_op;
    logic arith, logic_op, shift, alu, is_cmp, is_mov, is_lui, mem;
    logic is_load, is_stor, is_jal, is_jcond, is_bcond, take;
    logic unused;
    assign op = instr[15:12];
    assign ext = instr[7:4];
    assign unused = ^instr[3:0];
    // R-type ops live in ext; immediate ops carry the same code in the opcode field.
    assign fn = (op == OP_RTYPE) ? ext : op;
    assign arith = fn == F_ADD || fn == F_SUB || fn == F_CMP;
    assign logic_op = fn == F_AND || fn == F_OR || fn == F_XOR;
    assign shift = op == OP_SHIFT && (ext == EXT_LSH || ext == EXT_LSHI);
    assign alu = arith || logic_op || shift;
    assign is_cmp = fn == F_CMP;
    assign is_mov = fn == F_MOV;
    assign is_lui = op == OP_LUI;
    assign mem = op == OP_MEM;
    assign is_load = mem && ext == EXT_LOAD;
    assign is_stor = mem && ext == EXT_STOR;
    assign is_jal = mem && ext == EXT_JAL;
    assign is_jcond = mem && ext == EXT_JCOND;
    assign is_bcond = op == OP_BCOND;
    assign alu_op = shift ? ALU_LSH : fn == F_SUB ? ALU_SUB : fn == F_CMP ? ALU_CMP :
                    fn == F_AND ? ALU_AND : fn == F_OR ? ALU_OR : fn == F_XOR ? ALU_XOR : ALU_ADD;
    cond_eval u_cond (
        .cond  (instr[11:8]),
        .flags1(flags1),
        .flags2(flags2),
        .take  (take)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else state <= next;
    end
    always_comb begin
        next = S_FETCH;
        case (state)
            S_FETCH:  next = run ? S_LATCH : S_FETCH;
            S_LATCH:  next = S_DECODE;
            S_DECODE: next = S_EXEC;
            S_EXEC:   next = is_load ? S_MEMRD : S_FETCH;
            S_MEMRD:  next = S_LDWB;
            default:  next = S_FETCH;
        endcase
    end
    always_comb begin
        MemW1en = 1'b0;
        RFen = 1'b0;
        PSRen = 1'b0;
        PCen = 1'b0;
        INSTRen = 1'b0;
        Movm = 1'b0;
        A1m = 1'b0;
        setZNL = 1'b0;
        PCm = PC_INC;
        MAm = MA_PC;
        A2m = A2_REG;
        RWm = RW_MEM;
        aluOp = ALU_ADD;
        case (state)
            S_LATCH: INSTRen = 1'b1;
            S_EXEC: begin
                // Everything but LOAD retires here; undefined encodings fall through as a NOP.
                PCen = !is_load;
                if (alu) begin
                    RFen = !is_cmp;
                    RWm = RW_ALU;
                    Movm = 1'b1;
                    PSRen = 1'b1;
                    setZNL = arith;
                    aluOp = alu_op;
                    A2m = shift ? (ext == EXT_LSHI ? A2_SHAMT : A2_REG) : (op != OP_RTYPE ? A2_IMM : A2_REG);
                end else if (is_mov) begin
                    RFen = 1'b1;
                    RWm = RW_ALU;
                    A2m = op != OP_RTYPE ? A2_IMM : A2_REG;
                end else if (is_lui) begin
                    RFen = 1'b1;
                    RWm = RW_LUI;
                end else if (is_stor) begin
                    MAm = MA_REG;
                    MemW1en = 1'b1;
                end else if (is_load) begin
                    MAm = MA_REG;
                end else if (is_bcond) begin
                    A1m = 1'b1;
                    A2m = A2_IMM;
                    PCm = take ? PC_BR : PC_INC;
                end else if (is_jcond) begin
                    PCm = take ? PC_JMP : PC_INC;
                end else if (is_jal) begin
                    RWm = RW_PC;
                    RFen = 1'b1;
                    PCm = PC_JMP;
                end
            end
            S_MEMRD: MAm = MA_REG;
            S_LDWB: begin
                RWm = RW_MEM;
                RFen = 1'b1;
                PCen = 1'b1;
            end
            default: ;
        endcase
    end
    assign MemW2en = 1'b0;
    assign halted = state == S_FETCH && !run;
    assign state_dbg = state;
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: directed self-checking bench for the multicycle control FSM.
module tb_cpu_controller;
    import cpu_pkg::*;
    logic clk, reset, run;
    logic [15:0] instr;
    logic [1:0] flags1;
    logic [2:0] flags2;
    logic MemW1en, MemW2en, RFen, PSRen, PCen, INSTRen, Movm, A1m, setZNL, halted;
    logic [1:0] PCm, MAm, A2m, RWm;
    logic [3:0] aluOp;
    logic [2:0] state_dbg;
    logic [20:0] all_out;
    int tests = 0;
    int fails = 0;
    cpu_controller dut (
        .clk(clk), .reset(reset), .run(run), .instr(instr), .flags1(flags1), .flags2(flags2),
        .MemW1en(MemW1en), .MemW2en(MemW2en), .RFen(RFen), .PSRen(PSRen), .PCen(PCen),
        .INSTRen(INSTRen), .Movm(Movm), .A1m(A1m), .setZNL(setZNL), .PCm(PCm), .MAm(MAm),
        .A2m(A2m), .RWm(RWm), .aluOp(aluOp), .halted(halted), .state_dbg(state_dbg)
    );
    assign all_out = {MemW1en, MemW2en, RFen, PSRen, PCen, INSTRen, Movm, A1m, setZNL,
                      PCm, MAm, A2m, RWm, aluOp};
    initial clk = 1'b0;
    always #5 clk = ~clk;
    function automatic logic [20:0] e(int mw1, int rf, int psr, int pc, int ir, int movm, int a1m,
                                      int znl, int pcm, int mam, int a2m, int rwm, int alu);
        return {1'(mw1), 1'b0, 1'(rf), 1'(psr), 1'(pc), 1'(ir), 1'(movm), 1'(a1m), 1'(znl),
                2'(pcm), 2'(mam), 2'(a2m), 2'(rwm), 4'(alu)};
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic to_exec(input logic [15:0] i);
        instr = i;
        repeat (3) tick();
    endtask
    task automatic test_reset();
        reset = 1'b0; run = 1'b1; instr = 16'hF000; flags1 = 2'b00; flags2 = 3'b000;
        repeat (3) tick();
        tests++;
        if ({all_out, halted, state_dbg} !== 25'd0) begin
            fails++; $display("FAIL reset_outputs: got %h want 0", {all_out, halted, state_dbg});
        end
        reset = 1'b1;
        #1;
        tests++;
        if (state_dbg !== 3'd0) begin fails++; $display("FAIL release_state: got %0d want 0", state_dbg); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            tests++;
            if (state_dbg !== 3'(k % 4)) begin
                fails++; $display("FAIL reset_seq%0d: got %0d want %0d", k, state_dbg, k % 4);
            end
        end
    endtask
    task automatic test_add();
        instr = 16'h0152;
        tick();
        tests++;
        if (all_out !== e(0,0,0,0,1,0,0,0,0,0,0,0,0) || state_dbg !== 3'd1) begin
            fails++; $display("FAIL add_latch: got %h/%0d want %h/1", all_out, state_dbg, e(0,0,0,0,1,0,0,0,0,0,0,0,0));
        end
        tick();
        tests++;
        if (all_out !== 21'd0 || state_dbg !== 3'd2) begin
            fails++; $display("FAIL add_decode: got %h/%0d want 0/2", all_out, state_dbg);
        end
        tick();
        tests++;
        if (all_out !== e(0,1,1,1,0,1,0,1,0,0,0,2,ALU_ADD) || state_dbg !== 3'd3) begin
            fails++; $display("FAIL add_exec: got %h want %h", all_out, e(0,1,1,1,0,1,0,1,0,0,0,2,ALU_ADD));
        end
        tick();
        tests++;
        if (all_out !== 21'd0 || state_dbg !== 3'd0) begin
            fails++; $display("FAIL add_retire: got %h/%0d want 0/0", all_out, state_dbg);
        end
    endtask
    task automatic test_alu_classes();
        logic [15:0] ins [7];
        logic [20:0] want [7];
        ins[0] = 16'h0192; want[0] = e(0,1,1,1,0,1,0,1,0,0,0,2,ALU_SUB);
        ins[1] = 16'hB105; want[1] = e(0,0,1,1,0,1,0,1,0,0,2,2,ALU_CMP);
        ins[2] = 16'h0132; want[2] = e(0,1,1,1,0,1,0,0,0,0,0,2,ALU_XOR);
        ins[3] = 16'hD1FF; want[3] = e(0,1,0,1,0,0,0,0,0,0,2,2,ALU_ADD);
        ins[4] = 16'hE1AB; want[4] = e(0,1,0,1,0,0,0,0,0,0,0,3,ALU_ADD);
        ins[5] = 16'h8103; want[5] = e(0,1,1,1,0,1,0,0,0,0,1,2,ALU_LSH);
        ins[6] = 16'h0100; want[6] = e(0,0,0,1,0,0,0,0,0,0,0,0,ALU_ADD);
        for (int k = 0; k < 7; k++) begin
            to_exec(ins[k]);
            tests++;
            if (all_out !== want[k]) begin
                fails++; $display("FAIL alu_%h: got %h want %h", ins[k], all_out, want[k]);
            end
            tick();
        end
    endtask
    task automatic test_load();
        to_exec(16'h4100);
        tests++;
        if (all_out !== e(0,0,0,0,0,0,0,0,0,1,0,0,0)) begin
            fails++; $display("FAIL load_exec: got %h want %h", all_out, e(0,0,0,0,0,0,0,0,0,1,0,0,0));
        end
        tick();
        tests++;
        if (all_out !== e(0,0,0,0,0,0,0,0,0,1,0,0,0) || state_dbg !== 3'd4) begin
            fails++; $display("FAIL load_memrd: got %h/%0d want %h/4", all_out, state_dbg, e(0,0,0,0,0,0,0,0,0,1,0,0,0));
        end
        tick();
        tests++;
        if (all_out !== e(0,1,0,1,0,0,0,0,0,0,0,0,0) || state_dbg !== 3'd5) begin
            fails++; $display("FAIL load_ldwb: got %h/%0d want %h/5", all_out, state_dbg, e(0,1,0,1,0,0,0,0,0,0,0,0,0));
        end
        tick();
        tests++;
        if (state_dbg !== 3'd0) begin fails++; $display("FAIL load_retire: got %0d want 0", state_dbg); end
    endtask
    task automatic test_branch();
        flags2 = 3'b100;
        to_exec(16'hC0FE);
        tests++;
        if (all_out !== e(0,0,0,1,0,0,1,0,2,0,2,0,ALU_ADD)) begin
            fails++; $display("FAIL beq_taken: got %h want %h", all_out, e(0,0,0,1,0,0,1,0,2,0,2,0,ALU_ADD));
        end
        tick();
        flags2 = 3'b000;
        to_exec(16'hC0FE);
        tests++;
        if (all_out !== e(0,0,0,1,0,0,1,0,0,0,2,0,ALU_ADD)) begin
            fails++; $display("FAIL beq_not_taken: got %h want %h", all_out, e(0,0,0,1,0,0,1,0,0,0,2,0,ALU_ADD));
        end
        tick();
    endtask
    task automatic test_jcond();
        logic [15:0] ins [7];
        logic [1:0] f1 [7];
        logic [2:0] f2 [7];
        int pcm [7];
        ins[0] = 16'h4AC3; f1[0] = 2'b00; f2[0] = 3'b000; pcm[0] = 1;
        ins[1] = 16'h4AC3; f1[1] = 2'b00; f2[1] = 3'b001; pcm[1] = 0;
        ins[2] = 16'h42C0; f1[2] = 2'b10; f2[2] = 3'b000; pcm[2] = 1;
        ins[3] = 16'h4FC0; f1[3] = 2'b11; f2[3] = 3'b111; pcm[3] = 0;
        ins[4] = 16'h4EC0; f1[4] = 2'b00; f2[4] = 3'b000; pcm[4] = 1;
        ins[5] = 16'h4DC0; f1[5] = 2'b00; f2[5] = 3'b010; pcm[5] = 1;
        ins[6] = 16'h49C0; f1[6] = 2'b01; f2[6] = 3'b000; pcm[6] = 0;
        for (int k = 0; k < 7; k++) begin
            flags1 = f1[k]; flags2 = f2[k];
            to_exec(ins[k]);
            tests++;
            if (all_out !== e(0,0,0,1,0,0,0,0,pcm[k],0,0,0,ALU_ADD)) begin
                fails++; $display("FAIL jcond_%0d: got %h want %h", k, all_out, e(0,0,0,1,0,0,0,0,pcm[k],0,0,0,ALU_ADD));
            end
            tick();
        end
        flags1 = 2'b00; flags2 = 3'b000;
    endtask
    task automatic test_jal_undef();
        to_exec(16'h4E85);
        tests++;
        if (all_out !== e(0,1,0,1,0,0,0,0,1,0,0,1,ALU_ADD)) begin
            fails++; $display("FAIL jal: got %h want %h", all_out, e(0,1,0,1,0,0,0,0,1,0,0,1,ALU_ADD));
        end
        tick();
        to_exec(16'hF000);
        tests++;
        if (all_out !== e(0,0,0,1,0,0,0,0,0,0,0,0,ALU_ADD)) begin
            fails++; $display("FAIL undef: got %h want %h", all_out, e(0,0,0,1,0,0,0,0,0,0,0,0,ALU_ADD));
        end
        tick();
    endtask
    task automatic test_run_drop();
        int pulses = 0;
        instr = 16'h4142;
        repeat (2) tick();
        run = 1'b0;
        tick();
        tests++;
        if (all_out !== e(1,0,0,1,0,0,0,0,0,1,0,0,ALU_ADD)) begin
            fails++; $display("FAIL stor_exec: got %h want %h", all_out, e(1,0,0,1,0,0,0,0,0,1,0,0,ALU_ADD));
        end
        pulses += int'(MemW1en);
        for (int k = 0; k < 4; k++) begin
            tick();
            pulses += int'(MemW1en);
            tests++;
            if (state_dbg !== 3'd0 || halted !== 1'b1) begin
                fails++; $display("FAIL hold_%0d: got state %0d halted %b want 0 1", k, state_dbg, halted);
            end
        end
        tests++;
        if (pulses != 1) begin fails++; $display("FAIL stor_pulses: got %0d want 1", pulses); end
        run = 1'b1;
        #1;
        tests++;
        if (halted !== 1'b0) begin fails++; $display("FAIL unhalt: got %b want 0", halted); end
        tick();
        tests++;
        if (state_dbg !== 3'd1) begin fails++; $display("FAIL resume: got %0d want 1", state_dbg); end
        repeat (3) tick();
    endtask
    task automatic test_reset_abort();
        to_exec(16'h4100);
        tick();
        tests++;
        if (state_dbg !== 3'd4) begin fails++; $display("FAIL abort_setup: got %0d want 4", state_dbg); end
        reset = 1'b0;
        #1;
        tests++;
        if (all_out !== 21'd0 || state_dbg !== 3'd0) begin
            fails++; $display("FAIL abort_async: got %h/%0d want 0/0", all_out, state_dbg);
        end
        run = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if (RFen !== 1'b0 || state_dbg !== 3'd0) begin
                fails++; $display("FAIL abort_norf_%0d: got RFen %b state %0d want 0 0", k, RFen, state_dbg);
            end
        end
        run = 1'b1;
    endtask
    initial begin
        test_reset();
        test_add();
        test_alu_classes();
        test_load();
        test_branch();
        test_jcond();
        test_jal_undef();
        test_run_drop();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
